data_ram_bus: RTL and testbench

//  Clocked, parametrised data RAM and bus slave for the SoC data bus (cs/as/rdy handshake).

---
 rtl/data_ram_bus_pkg.sv | 19 +
 rtl/data_ram_bus_if.sv | 35 +++
 rtl/data_ram_lane.sv | 25 ++
 rtl/data_ram_bus.sv | 119 +++++++++++
 tb/tb_data_ram_bus.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_ram_bus_pkg.sv
// Shared types and constants for the data RAM bus slave.
package data_ram_bus_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int unsigned WORD_DATA_W = 32;
  localparam int unsigned WORD_ADDR_W = 32;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned WCNT_W      = 4;

  typedef enum logic [1:0] {
    DRB_IDLE   = 2'd0,
    DRB_WAIT   = 2'd1,
    DRB_ACCESS = 2'd2,
    DRB_RESP   = 2'd3
  } drb_state_e;

endpackage

// File: rtl/data_ram_bus_if.sv
// cs/as/rdy data bus plus the write-snoop side channel.
interface data_ram_bus_if
  import data_ram_bus_pkg::*;
#(
  parameter int unsigned DATA_W = WORD_DATA_W,
  parameter int unsigned ADDR_W = WORD_ADDR_W
);

  localparam int unsigned LANES = DATA_W / BYTE_W;

  logic              cs;
  logic              as;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [LANES-1:0]  be;
  logic [DATA_W-1:0] rd_data;
  logic              rdy;
  logic              err;
  logic              snoop_we;
  logic [ADDR_W-1:0] snoop_addr;
  logic [DATA_W-1:0] snoop_data;
  logic [LANES-1:0]  snoop_be;

  modport master (
    output cs, as, rw, addr, wr_data, be,
    input  rd_data, rdy, err, snoop_we, snoop_addr, snoop_data, snoop_be
  );

  modport slave (
    input  cs, as, rw, addr, wr_data, be,
    output rd_data, rdy, err, snoop_we, snoop_addr, snoop_data, snoop_be
  );

endinterface

// File: rtl/data_ram_lane.sv
// One byte lane of the data RAM: synchronous single-port, read-first.
module data_ram_lane
  import data_ram_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned IDX_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout
);

  logic [BYTE_W-1:0] mem [DEPTH];

  // Write when enabled; the addressed byte is registered every cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= din;
    end
    dout <= mem[idx];
  end

endmodule

// File: rtl/data_ram_bus.sv
// Clocked data RAM bus slave: byte strobes, wait states, range error, write snoop.
module data_ram_bus
  import data_ram_bus_pkg::*;
#(
  parameter int unsigned DATA_W      = WORD_DATA_W,
  parameter int unsigned ADDR_W      = WORD_ADDR_W,
  parameter int unsigned DEPTH       = 4096,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic         clk,
  input  logic         rst,
  data_ram_bus_if.slave bus
);

  localparam int unsigned LANES = DATA_W / BYTE_W;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] DEPTH_64 = 64'(DEPTH);
  localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(WAIT_CYCLES - 1);

  drb_state_e        state;
  logic [WCNT_W-1:0] wcnt;
  logic              rw_q;
  logic              oor_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [LANES-1:0]  be_q;

  logic              req;
  logic              commit;
  logic [LANES-1:0]  lane_we;
  logic [IDX_W-1:0]  ram_idx;
  logic [DATA_W-1:0] ram_dout;

  assign req     = bus.cs & bus.as;
  assign commit  = (state == DRB_ACCESS) && (rw_q == ENABLE) && !oor_q;
  assign lane_we = commit ? be_q : '0;

  // In IDLE the RAM is addressed straight from the bus so a read issued at accept
  // already has its word in the lane registers by the ACCESS edge, even with no wait states.
  assign ram_idx = (state == DRB_IDLE) ? bus.addr[IDX_W-1:0] : addr_q[IDX_W-1:0];

  // One byte-wide RAM per lane; lane i owns data bits [8i+7:8i].
  for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
    data_ram_lane #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
    ) u_lane (
      .clk  (clk),
      .we   (lane_we[i]),
      .idx  (ram_idx),
      .din  (wdata_q[i*BYTE_W +: BYTE_W]),
      .dout (ram_dout[i*BYTE_W +: BYTE_W])
    );
  end

  // Request FSM, wait counter, request latches and registered response/snoop outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= DRB_IDLE;
      wcnt           <= '0;
      rw_q           <= DISABLE;
      oor_q          <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      be_q           <= '0;
      bus.rdy        <= 1'b0;
      bus.err        <= 1'b0;
      bus.rd_data    <= '0;
      bus.snoop_we   <= 1'b0;
      bus.snoop_addr <= '0;
      bus.snoop_data <= '0;
      bus.snoop_be   <= '0;
    end else begin
      bus.rdy      <= 1'b0;
      bus.err      <= 1'b0;
      bus.snoop_we <= 1'b0;
      case (state)
        DRB_IDLE: begin
          if (req) begin
            rw_q    <= bus.rw;
            addr_q  <= bus.addr;
            wdata_q <= bus.wr_data;
            be_q    <= bus.be;
            oor_q   <= 64'(bus.addr) >= DEPTH_64;
            wcnt    <= WAIT_LOAD;
            state   <= (WAIT_CYCLES > 0) ? DRB_WAIT : DRB_ACCESS;
          end
        end
        DRB_WAIT: begin
          if (wcnt == '0) begin
            state <= DRB_ACCESS;
          end else begin
            wcnt <= wcnt - WCNT_W'(1);
          end
        end
        DRB_ACCESS: begin
          bus.rdy <= 1'b1;
          bus.err <= oor_q;
          if (rw_q == DISABLE) begin
            bus.rd_data <= oor_q ? '0 : ram_dout;
          end else if (!oor_q) begin
            bus.snoop_we   <= 1'b1;
            bus.snoop_addr <= addr_q;
            bus.snoop_data <= wdata_q;
            bus.snoop_be   <= be_q;
          end
          state <= DRB_RESP;
        end
        DRB_RESP: begin
          state <= DRB_IDLE;
        end
        default: begin
          state <= DRB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram_bus.sv
// Scoreboard bench for data_ram_bus: three instances with 0, 3 and 4 wait states share one driver.
module tb_data_ram_bus;
  import data_ram_bus_pkg::*;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEPTH  = 4096;
  localparam int unsigned W_A    = 0;
  localparam int unsigned W_B    = 3;
  localparam int unsigned W_C    = 4;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared master-side stimulus; sel picks which instance sees cs.
  logic [1:0]  sel;
  logic        cs;
  logic        strobe;
  logic        rw;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [3:0]  be;

  data_ram_bus_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_a ();
  data_ram_bus_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_b ();
  data_ram_bus_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_c ();

  assign bus_a.cs = cs & (sel == 2'd0);
  assign bus_b.cs = cs & (sel == 2'd1);
  assign bus_c.cs = cs & (sel == 2'd2);
  assign bus_a.as = strobe;
  assign bus_b.as = strobe;
  assign bus_c.as = strobe;
  assign bus_a.rw = rw;
  assign bus_b.rw = rw;
  assign bus_c.rw = rw;
  assign bus_a.addr = addr;
  assign bus_b.addr = addr;
  assign bus_c.addr = addr;
  assign bus_a.wr_data = wr_data;
  assign bus_b.wr_data = wr_data;
  assign bus_c.wr_data = wr_data;
  assign bus_a.be = be;
  assign bus_b.be = be;
  assign bus_c.be = be;

  data_ram_bus #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(W_A))
    u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  data_ram_bus #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(W_B))
    u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  data_ram_bus #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(W_C))
    u_dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  // Outputs of the selected instance.
  logic        rdy_m, err_m, swe_m;
  logic [31:0] rdd_m, sad_m, sdt_m;
  logic [3:0]  sbe_m;

  always_comb begin
    case (sel)
      2'd1: begin
        rdy_m = bus_b.rdy; err_m = bus_b.err; swe_m = bus_b.snoop_we; rdd_m = bus_b.rd_data;
        sad_m = bus_b.snoop_addr; sdt_m = bus_b.snoop_data; sbe_m = bus_b.snoop_be;
      end
      2'd2: begin
        rdy_m = bus_c.rdy; err_m = bus_c.err; swe_m = bus_c.snoop_we; rdd_m = bus_c.rd_data;
        sad_m = bus_c.snoop_addr; sdt_m = bus_c.snoop_data; sbe_m = bus_c.snoop_be;
      end
      default: begin
        rdy_m = bus_a.rdy; err_m = bus_a.err; swe_m = bus_a.snoop_we; rdd_m = bus_a.rd_data;
        sad_m = bus_a.snoop_addr; sdt_m = bus_a.snoop_data; sbe_m = bus_a.snoop_be;
      end
    endcase
  end

  function automatic int unsigned wait_of(input logic [1:0] s);
    case (s)
      2'd1:    return W_B;
      2'd2:    return W_C;
      default: return W_A;
    endcase
  endfunction

  typedef struct {
    logic [1:0]  sel;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
    int unsigned acc;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rd [3] = '{default: 32'h0};

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  // Monitor: pops one expectation per rdy strobe; rdy low means err and snoop_we must be low.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      foreach (last_rd[i]) last_rd[i] = 32'h0;
    end else if (rdy_m) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rdy: got rdy=1 at cycle %0d, expected no response", cyc);
      end else begin
        e = sbq.pop_front();
        // rdy rises WAIT+1 edges after the accept edge, i.e. it is high in cycle T+2+WAIT.
        check({e.name, "/latency"}, 32'(cyc - e.acc), 32'(wait_of(e.sel) + 1));
        check({e.name, "/err"}, 32'(err_m), 32'(e.exp_err));
        if (!e.wr) begin
          check({e.name, "/rd_data"}, rdd_m, e.exp_rd);
          last_rd[e.sel] = e.exp_rd;
        end else begin
          check({e.name, "/rd_data_hold"}, rdd_m, last_rd[e.sel]);
        end
        check({e.name, "/snoop_we"}, 32'(swe_m), 32'(e.wr & ~e.exp_err));
        if (e.wr && !e.exp_err) begin
          check({e.name, "/snoop_addr"}, sad_m, e.addr);
          check({e.name, "/snoop_data"}, sdt_m, e.data);
          check({e.name, "/snoop_be"}, 32'(sbe_m), 32'(e.be));
        end
      end
    end else begin
      check("idle_err", 32'(err_m), 32'h0);
      check("idle_snoop_we", 32'(swe_m), 32'h0);
    end
  end

  // Issue one request at a negedge, push its expectation at accept, pace to the next IDLE.
  task automatic issue(input string name, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b, input logic [31:0] exp_rd,
                       input logic exp_err, input bit hold, input bit toggle);
    exp_t e;
    bit   seen;
    cs = 1'b1; strobe = 1'b1; rw = wr; addr = a; wr_data = d; be = b;
    @(posedge clk);
    #1;
    e.sel = sel; e.wr = wr; e.addr = a; e.data = d; e.be = b;
    e.exp_rd = exp_rd; e.exp_err = exp_err; e.acc = cyc; e.name = name;
    sbq.push_back(e);
    seen = 1'b0;
    for (int k = 0; k < 64 && !seen; k++) begin
      @(negedge clk);
      if (rdy_m) begin
        seen = 1'b1;
      end else if (toggle) begin
        cs   = ~cs;
        addr = $urandom();
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s/timeout: got no rdy within 64 cycles, expected rdy", name);
    end
    if (!hold) begin
      cs = 1'b0; strobe = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; sel = 2'd0; cs = 1'b0; strobe = 1'b0; rw = 1'b0;
    addr = '0; wr_data = '0; be = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("reset/rdy", 32'(rdy_m), 32'h0);
    check("reset/err", 32'(err_m), 32'h0);
    check("reset/snoop_we", 32'(swe_m), 32'h0);
    check("reset/rd_data", rdd_m, 32'h0);

    // Reset in the middle of WAIT (3 wait states) discards the pending write
    sel = 2'd1;
    issue("t1_wr9", 1'b1, 32'd9, 32'h0A0A0A0A, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0);
    issue("t1_rd9", 1'b0, 32'd9, 32'h0, 4'hF, 32'h0A0A0A0A, 1'b0, 1'b0, 1'b0);
    cs = 1'b1; strobe = 1'b1; rw = 1'b1; addr = 32'd9; wr_data = 32'hFFFFFFFF; be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t1_midrst/rdy", 32'(rdy_m), 32'h0);
    check("t1_midrst/err", 32'(err_m), 32'h0);
    check("t1_midrst/snoop_we", 32'(swe_m), 32'h0);
    check("t1_midrst/rd_data", rdd_m, 32'h0);
    cs = 1'b0; strobe = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    issue("t1_rd9_after_rst", 1'b0, 32'd9, 32'h0, 4'hF, 32'h0A0A0A0A, 1'b0, 1'b0, 1'b0);

    // Full-word write and read-back, no wait states
    sel = 2'd0;
    @(negedge clk);
    issue("t2_wr5", 1'b1, 32'd5, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0);
    issue("t2_rd5", 1'b0, 32'd5, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);

    // Byte-lane writes; be=0 still answers and snoops
    issue("t3_wr5_be5", 1'b1, 32'd5, 32'h11223344, 4'b0101, 32'h0, 1'b0, 1'b0, 1'b0);
    issue("t3_rd5", 1'b0, 32'd5, 32'h0, 4'hF, 32'hDE22BE44, 1'b0, 1'b0, 1'b0);
    issue("t3_wr5_be0", 1'b1, 32'd5, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, 1'b0, 1'b0);
    issue("t3_rd5_be0", 1'b0, 32'd5, 32'h0, 4'hF, 32'hDE22BE44, 1'b0, 1'b0, 1'b0);

    // Out of range and the last in-range word
    issue("t5_rd4096", 1'b0, 32'd4096, 32'h0, 4'hF, 32'h0, 1'b1, 1'b0, 1'b0);
    issue("t5_wr1005", 1'b1, 32'h1005, 32'h99999999, 4'hF, 32'h0, 1'b1, 1'b0, 1'b0);
    issue("t5_rd5", 1'b0, 32'd5, 32'h0, 4'hF, 32'hDE22BE44, 1'b0, 1'b0, 1'b0);
    issue("t5_wr4095", 1'b1, 32'd4095, 32'h12345678, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0);
    issue("t5_rd4095", 1'b0, 32'd4095, 32'h0, 4'hF, 32'h12345678, 1'b0, 1'b0, 1'b0);

    // Four wait states; cs/addr toggling during the wait is ignored
    sel = 2'd2;
    @(negedge clk);
    issue("t4_wr3", 1'b1, 32'd3, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0);
    issue("t4_rd3_toggle", 1'b0, 32'd3, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, 1'b0, 1'b1);

    // Back-to-back with cs&as held high: write then read each of addrs 0..7
    sel = 2'd0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      issue($sformatf("t6_wr%0d", i), 1'b1, 32'(i), 32'hC0DE0000 + 32'(i), 4'hF,
            32'h0, 1'b0, 1'b1, 1'b0);
      issue($sformatf("t6_rd%0d", i), 1'b0, 32'(i), 32'h0, 4'hF,
            32'hC0DE0000 + 32'(i), 1'b0, (i < 7), 1'b0);
    end

    repeat (6) @(negedge clk);
    check("scoreboard_empty", 32'(sbq.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
